updi_bridge_sequencer: RTL and testbench

- Timed successor to the combinational UART/UPDI bridge mode selector.
- Drives `bridge_mode` from a registered FSM with three timed behaviours:
  - parametrised BREAK generation: length, gap and repeat count;
  - a TX->RX turnaround window in which the line is held idle;
  - break pre-emption of any transfer.
- Sits between the UPDI transaction engine (drives `wr_en`/`break_req`) and the UART/UPDI bridge (consumes `bridge_mode`).

---
 rtl/updi_pkg.sv | 32 +++
 rtl/updi_down_counter.sv | 28 ++
 rtl/updi_bridge_sequencer.sv | 152 +++++++++++++++
 tb/tb_updi_bridge_sequencer.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/updi_pkg.sv
// Shared UPDI types and timing defaults for the bridge sequencer and its helpers.
package updi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BREAK = 2'd1,
        TX    = 2'd2,
        RX    = 2'd3
    } updi_bridge_mode;

    typedef enum logic [2:0] {
        ST_RX    = 3'd0,
        ST_TX    = 3'd1,
        ST_TURN  = 3'd2,
        ST_BREAK = 3'd3,
        ST_GAP   = 3'd4
    } updi_seq_state;

    // Defaults assume a 100 MHz clk: 240 us BREAK, 24 us gap.
    localparam int unsigned UPDI_BREAK_CYCLES = 24000;
    localparam int unsigned UPDI_GAP_CYCLES   = 2400;
    localparam int unsigned UPDI_NUM_BREAKS   = 2;
    localparam int unsigned UPDI_TURN_CYCLES  = 8;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/updi_down_counter.sv
// Load/decrement counter with a registered zero flag; holds at zero instead of wrapping.
module updi_down_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            zero <= 1'b1;
        end else if (load) begin
            cnt  <= load_val;
            zero <= (load_val == '0);
        end else if (dec && !zero) begin
            cnt  <= cnt - W'(1);
            zero <= (cnt == W'(1));
        end
    end

endmodule

// File: rtl/updi_bridge_sequencer.sv
// Registered UPDI bridge mode sequencer: timed BREAK/GAP trains, TX->RX turnaround,
// and break pre-emption of any transfer.
module updi_bridge_sequencer
    import updi_pkg::*;
#(
    parameter int unsigned BREAK_CYCLES = UPDI_BREAK_CYCLES,
    parameter int unsigned GAP_CYCLES   = UPDI_GAP_CYCLES,
    parameter int unsigned NUM_BREAKS   = UPDI_NUM_BREAKS,
    parameter int unsigned TURN_CYCLES  = UPDI_TURN_CYCLES
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wr_en,
    input  logic            break_req,
    output updi_bridge_mode bridge_mode,
    output logic            tx_grant,
    output logic            busy,
    output logic            break_done
);

    localparam int unsigned CNT_W = $clog2(max3(BREAK_CYCLES, GAP_CYCLES, TURN_CYCLES) + 1);
    localparam int unsigned BRK_W = $clog2(NUM_BREAKS + 1);

    if (BREAK_CYCLES < 1 || GAP_CYCLES < 1 || TURN_CYCLES < 1 || NUM_BREAKS < 1) begin : g_param_check
        $error("updi_bridge_sequencer: timing parameters and NUM_BREAKS must be >= 1");
    end

    updi_seq_state   state, state_d;
    logic [BRK_W-1:0] brk_cnt;
    logic             brk_clr, brk_inc, done_d;
    logic             cnt_load, cnt_dec, cnt_zero;
    logic [CNT_W-1:0] cnt_load_val;
    updi_bridge_mode  mode_d;
    logic             tx_grant_d, busy_d;

    updi_down_counter #(.W(CNT_W)) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    // State, break counter and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_RX;
            brk_cnt     <= '0;
            bridge_mode <= RX;
            tx_grant    <= 1'b0;
            busy        <= 1'b0;
            break_done  <= 1'b0;
        end else begin
            state <= state_d;
            if (brk_clr) begin
                brk_cnt <= '0;
            end else if (brk_inc) begin
                brk_cnt <= brk_cnt + BRK_W'(1);
            end
            bridge_mode <= mode_d;
            tx_grant    <= tx_grant_d;
            busy        <= busy_d;
            break_done  <= done_d;
        end
    end

    // Next state and counter control; break_req is only honoured outside BREAK/GAP.
    always_comb begin
        state_d      = state;
        cnt_load     = 1'b0;
        cnt_dec      = 1'b0;
        cnt_load_val = '0;
        brk_clr      = 1'b0;
        brk_inc      = 1'b0;
        done_d       = 1'b0;
        if (break_req && (state == ST_RX || state == ST_TX || state == ST_TURN)) begin
            state_d      = ST_BREAK;
            cnt_load     = 1'b1;
            cnt_load_val = CNT_W'(BREAK_CYCLES - 1);
            brk_clr      = 1'b1;
        end else begin
            case (state)
                ST_RX: begin
                    if (wr_en) state_d = ST_TX;
                end
                ST_TX: begin
                    if (!wr_en) begin
                        state_d      = ST_TURN;
                        cnt_load     = 1'b1;
                        cnt_load_val = CNT_W'(TURN_CYCLES - 1);
                    end
                end
                ST_TURN: begin
                    if (cnt_zero) state_d = wr_en ? ST_TX : ST_RX;
                    else          cnt_dec = 1'b1;
                end
                ST_BREAK: begin
                    if (!cnt_zero) begin
                        cnt_dec = 1'b1;
                    end else if (brk_cnt == BRK_W'(NUM_BREAKS - 1)) begin
                        state_d = ST_RX;
                        done_d  = 1'b1;
                    end else begin
                        state_d      = ST_GAP;
                        cnt_load     = 1'b1;
                        cnt_load_val = CNT_W'(GAP_CYCLES - 1);
                        brk_inc      = 1'b1;
                    end
                end
                ST_GAP: begin
                    if (cnt_zero) begin
                        state_d      = ST_BREAK;
                        cnt_load     = 1'b1;
                        cnt_load_val = CNT_W'(BREAK_CYCLES - 1);
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
                default: state_d = ST_RX;
            endcase
        end
    end

    // Output values for the state being entered, registered alongside it.
    always_comb begin
        mode_d     = RX;
        tx_grant_d = 1'b0;
        busy_d     = 1'b0;
        case (state_d)
            ST_RX:    mode_d = RX;
            ST_TX: begin
                mode_d     = TX;
                tx_grant_d = 1'b1;
            end
            ST_TURN: begin
                mode_d = IDLE;
                busy_d = 1'b1;
            end
            ST_BREAK: begin
                mode_d = BREAK;
                busy_d = 1'b1;
            end
            ST_GAP: begin
                mode_d = IDLE;
                busy_d = 1'b1;
            end
            default:  mode_d = RX;
        endcase
    end

endmodule

// File: tb/tb_updi_bridge_sequencer.sv
// Table-driven bench for updi_bridge_sequencer with BREAK=4, GAP=2, NUM=2, TURN=3.
module tb_updi_bridge_sequencer;
    import updi_pkg::*;

    logic            clk = 1'b0;
    logic            rst;
    logic            wr_en;
    logic            break_req;
    updi_bridge_mode bridge_mode;
    logic            tx_grant;
    logic            busy;
    logic            break_done;

    typedef struct {
        logic            wr;
        logic            brk;
        updi_bridge_mode mode;
        logic            grant;
        logic            bsy;
        logic            done;
    } vec_t;

    vec_t       vecs[$];
    logic [4:0] sb[$];
    int         errors = 0;
    int         checks = 0;
    int         vec_no = 0;

    updi_bridge_sequencer #(
        .BREAK_CYCLES (4),
        .GAP_CYCLES   (2),
        .NUM_BREAKS   (2),
        .TURN_CYCLES  (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .break_req   (break_req),
        .bridge_mode (bridge_mode),
        .tx_grant    (tx_grant),
        .busy        (busy),
        .break_done  (break_done)
    );

    always #5 clk = ~clk;

    task automatic add(input logic wr, input logic brk, input updi_bridge_mode m,
                       input logic g, input logic b, input logic d, input int n);
        vec_t v;
        v.wr = wr; v.brk = brk; v.mode = m; v.grant = g; v.bsy = b; v.done = d;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endtask

    // Full double-break from RX with inputs otherwise idle: 4 BREAK, 2 IDLE, 4 BREAK, RX+done.
    task automatic add_full_break();
        add(0, 1, BREAK, 0, 1, 0, 1);
        add(0, 0, BREAK, 0, 1, 0, 3);
        add(0, 0, IDLE,  0, 1, 0, 2);
        add(0, 0, BREAK, 0, 1, 0, 4);
        add(0, 0, RX,    0, 0, 1, 1);
        add(0, 0, RX,    0, 0, 0, 1);
    endtask

    task automatic check_out(input string name, input logic [4:0] exp);
        logic [4:0] act;
        act = {bridge_mode, tx_grant, busy, break_done};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: mode/grant/busy/done got %b required %b", name, act, exp);
        end
    endtask

    // Called just after a negedge; each vector spans exactly one posedge.
    task automatic run_vectors();
        vec_t v;
        while (vecs.size() > 0) begin
            v = vecs.pop_front();
            wr_en     = v.wr;
            break_req = v.brk;
            sb.push_back({v.mode, v.grant, v.bsy, v.done});
            @(negedge clk);
            check_out($sformatf("vec%0d", vec_no), sb.pop_front());
            vec_no++;
        end
        break_req = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        wr_en     = 1'b0;
        break_req = 1'b0;
        repeat (2) @(negedge clk);
        check_out("reset_values", {RX, 1'b0, 1'b0, 1'b0});
        rst = 1'b0;

        // Single break request from RX.
        add_full_break();
        // TX grant and plain turnaround.
        add(1, 0, TX,   1, 0, 0, 2);
        add(0, 0, IDLE, 0, 1, 0, 3);
        add(0, 0, RX,   0, 0, 0, 2);
        // wr_en re-rises inside turnaround: full window, then straight to TX.
        add(1, 0, TX,   1, 0, 0, 1);
        add(0, 0, IDLE, 0, 1, 0, 1);
        add(1, 0, IDLE, 0, 1, 0, 2);
        add(1, 0, TX,   1, 0, 0, 2);
        // Break pre-empts TX; repeat request during GAP is ignored.
        add(1, 1, BREAK, 0, 1, 0, 1);
        add(0, 0, BREAK, 0, 1, 0, 3);
        add(0, 0, IDLE,  0, 1, 0, 1);
        add(0, 1, IDLE,  0, 1, 0, 1);
        add(0, 0, BREAK, 0, 1, 0, 4);
        add(0, 0, RX,    0, 0, 1, 1);
        add(0, 0, RX,    0, 0, 0, 1);
        // Break and wr_en together: break wins, then RX one cycle, then TX.
        add(1, 1, BREAK, 0, 1, 0, 1);
        add(1, 0, BREAK, 0, 1, 0, 3);
        add(1, 0, IDLE,  0, 1, 0, 2);
        add(1, 0, BREAK, 0, 1, 0, 4);
        add(1, 0, RX,    0, 0, 1, 1);
        add(1, 0, TX,    1, 0, 0, 1);
        add(0, 0, IDLE,  0, 1, 0, 3);
        add(0, 0, RX,    0, 0, 0, 1);
        // Break pre-empts a turnaround.
        add(1, 0, TX,    1, 0, 0, 1);
        add(0, 0, IDLE,  0, 1, 0, 1);
        add(0, 1, BREAK, 0, 1, 0, 1);
        add(0, 0, BREAK, 0, 1, 0, 3);
        add(0, 0, IDLE,  0, 1, 0, 2);
        add(0, 0, BREAK, 0, 1, 0, 4);
        add(0, 0, RX,    0, 0, 1, 1);
        add(0, 0, RX,    0, 0, 0, 1);
        run_vectors();

        // Run into the second BREAK, then reset asynchronously mid-cycle.
        add(0, 1, BREAK, 0, 1, 0, 1);
        add(0, 0, BREAK, 0, 1, 0, 3);
        add(0, 0, IDLE,  0, 1, 0, 2);
        add(0, 0, BREAK, 0, 1, 0, 2);
        run_vectors();
        #2 rst = 1'b1;
        #1 check_out("async_reset", {RX, 1'b0, 1'b0, 1'b0});
        @(negedge clk);
        check_out("reset_held", {RX, 1'b0, 1'b0, 1'b0});
        rst = 1'b0;

        // A fresh request after reset yields a complete sequence.
        add_full_break();
        run_vectors();

        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d leftover required 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
